// File: rtl/dmem_pkg.sv
// Shared types, size encodings and lane extract/merge helpers for the data-memory controller.
package dmem_pkg;

  localparam int unsigned ADDR_BITS  = 13;
  localparam int unsigned WORD_IDX_W = 11;
  localparam int unsigned DATA_W     = 32;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {IDLE, WR, RD, RMW_RD, RMW_WR, RESP} state_e;

  typedef struct packed {
    logic                 we;
    logic [1:0]           size;
    logic                 uns;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_W-1:0]    wdata;
  } txn_t;

  function automatic logic [WORD_IDX_W-1:0] word_idx(input txn_t t);
    return t.addr[ADDR_BITS-1:2];
  endfunction

  function automatic logic access_err(input txn_t t, input int unsigned depth);
    logic [ADDR_BITS-3:0] idx;
    idx = t.addr[ADDR_BITS-1:2];
    return ((t.size == SZ_WORD) && (t.addr[1:0] != 2'b00)) ||
           ((t.size == SZ_HALF) && t.addr[0]) ||
           (t.size == 2'b11) ||
           (32'(idx) >= depth);
  endfunction

  // Pull the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] w,
                                                     input logic [1:0] size,
                                                     input logic [1:0] off,
                                                     input logic uns);
    logic [DATA_W-1:0] sh;
    logic [7:0]        b;
    logic [15:0]       h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Replace the addressed lane of a memory word with the low bits of the store data.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] w,
                                                   input logic [DATA_W-1:0] wd,
                                                   input logic [1:0] size,
                                                   input logic [1:0] off);
    logic [DATA_W-1:0] mask;
    mask = 32'h0000_00FF << {off, 3'b000};
    case (size)
      SZ_BYTE: return (w & ~mask) | (32'(wd[7:0]) << {off, 3'b000});
      SZ_HALF: return off[1] ? {wd[15:0], w[15:0]} : {w[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin arbiter; ties go to the port not granted last time.
module dmem_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      gnt[0] = req[0] & (~req[1] | last_q);
      gnt[1] = req[1] & (~req[0] | ~last_q);
    end
  end

  // last starts at 1 so port 0 takes the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: two arbitrated requesters, one access in flight,
// sub-word loads with extension and sub-word stores by read-modify-write.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [1:0]            p0_size,
  input  logic                  p0_uns,
  input  logic [ADDR_W-1:0]     p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rsp,
  output logic                  p0_err,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [1:0]            p1_size,
  input  logic                  p1_uns,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rsp,
  output logic                  p1_err,
  output logic [31:0]           p1_rdata,
  output logic                  dm_w,
  output logic                  dm_r,
  output logic [1:0]            store_format_signal,
  output logic [WORD_IDX_W-1:0] dm_addr,
  output logic [31:0]           dm_wdata,
  input  logic [31:0]           dm_rdata
);

  state_e                state_q, state_d;
  txn_t                  txn_q, txn_d, win;
  logic                  owner_q, owner_d;
  logic [1:0]            req, gnt;
  logic                  arb_en;
  logic                  dm_w_q, dm_w_d, dm_r_q, dm_r_d;
  logic [WORD_IDX_W-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]           dm_wdata_q, dm_wdata_d;
  logic [1:0]            rsp_q, rsp_d, err_q, err_d;
  logic [1:0][31:0]      rdata_q, rdata_d;

  assign req    = {p1_req, p0_req};
  assign arb_en = (state_q == IDLE);

  dmem_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_comb begin
    if (gnt[1]) begin
      win = '{we: p1_we, size: p1_size, uns: p1_uns, addr: ADDR_BITS'(p1_addr), wdata: p1_wdata};
    end else begin
      win = '{we: p0_we, size: p0_size, uns: p0_uns, addr: ADDR_BITS'(p0_addr), wdata: p0_wdata};
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    owner_d    = owner_q;
    dm_w_d     = 1'b0;
    dm_r_d     = 1'b0;
    dm_addr_d  = '0;
    dm_wdata_d = '0;
    rsp_d      = 2'b00;
    err_d      = 2'b00;
    rdata_d    = '0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          txn_d   = win;
          owner_d = gnt[1];
          if (access_err(win, DEPTH)) begin
            state_d        = RESP;
            rsp_d[gnt[1]]  = 1'b1;
            err_d[gnt[1]]  = 1'b1;
          end else if (!win.we) begin
            state_d   = RD;
            dm_r_d    = 1'b1;
            dm_addr_d = word_idx(win);
          end else if (win.size == SZ_WORD) begin
            state_d    = WR;
            dm_w_d     = 1'b1;
            dm_addr_d  = word_idx(win);
            dm_wdata_d = win.wdata;
          end else begin
            state_d   = RMW_RD;
            dm_r_d    = 1'b1;
            dm_addr_d = word_idx(win);
          end
        end
      end
      WR: begin
        state_d        = RESP;
        rsp_d[owner_q] = 1'b1;
      end
      RD: begin
        state_d          = RESP;
        rsp_d[owner_q]   = 1'b1;
        rdata_d[owner_q] = lane_extract(dm_rdata, txn_q.size, txn_q.addr[1:0], txn_q.uns);
      end
      // The merged word is formed from the read data and held in the write register
      RMW_RD: begin
        state_d    = RMW_WR;
        dm_w_d     = 1'b1;
        dm_addr_d  = word_idx(txn_q);
        dm_wdata_d = lane_merge(dm_rdata, txn_q.wdata, txn_q.size, txn_q.addr[1:0]);
      end
      RMW_WR: begin
        state_d        = RESP;
        rsp_d[owner_q] = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      txn_q      <= '0;
      owner_q    <= 1'b0;
      dm_w_q     <= 1'b0;
      dm_r_q     <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rsp_q      <= 2'b00;
      err_q      <= 2'b00;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      txn_q      <= txn_d;
      owner_q    <= owner_d;
      dm_w_q     <= dm_w_d;
      dm_r_q     <= dm_r_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      rsp_q      <= rsp_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign p0_gnt              = gnt[0];
  assign p1_gnt              = gnt[1];
  assign p0_rsp              = rsp_q[0];
  assign p1_rsp              = rsp_q[1];
  assign p0_err              = err_q[0];
  assign p1_err              = err_q[1];
  assign p0_rdata            = rdata_q[0];
  assign p1_rdata            = rdata_q[1];
  assign dm_w                = dm_w_q;
  assign dm_r                = dm_r_q;
  assign dm_addr             = dm_addr_q;
  assign dm_wdata            = dm_wdata_q;
  assign store_format_signal = 2'b00;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed requests push expected responses, a monitor checks them.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, we, uns, gnt, rsp, err;
  logic [1:0]  sz    [2];
  logic [12:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        dm_w, dm_r;
  logic [1:0]  sfmt;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [31:0] mem [1024];

  exp_t        q0[$], q1[$];
  int          grant_log[$];
  int          total = 0, passed = 0, cyc = 0;
  int          gnt_cyc[2];
  int          strobe_cnt = 0, both_cnt = 0, stray = 0;
  logic [10:0] last_rd_addr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dm_rdata = dm_r ? mem[dm_addr[9:0]] : 32'h0;
  always @(posedge clk) if (dm_w) mem[dm_addr[9:0]] <= dm_wdata;

  dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_size(sz[0]), .p0_uns(uns[0]), .p0_addr(addr[0]),
    .p0_wdata(wdata[0]), .p0_gnt(gnt[0]), .p0_rsp(rsp[0]), .p0_err(err[0]), .p0_rdata(rdata[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_size(sz[1]), .p1_uns(uns[1]), .p1_addr(addr[1]),
    .p1_wdata(wdata[1]), .p1_gnt(gnt[1]), .p1_rsp(rsp[1]), .p1_err(err[1]), .p1_rdata(rdata[1]),
    .dm_w(dm_w), .dm_r(dm_r), .store_format_signal(sfmt), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_evt(input string name, input string what);
    total++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Queue the expected response, then present the request until granted.
  task automatic issue(input int p, input logic w, input logic [1:0] s, input logic u,
                       input logic [12:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd, input int e_lat);
    exp_t x;
    bit   ok;
    ok      = 1'b0;
    x.err   = e_err;
    x.rdata = e_rd;
    x.lat   = e_lat;
    if (p == 0) q0.push_back(x); else q1.push_back(x);
    @(negedge clk);
    we[p] = w; sz[p] = s; uns[p] = u; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      #1;
      if (gnt[p]) ok = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    #1;
    req[p] = 1'b0;
    if (!ok) fail_evt($sformatf("p%0d_gnt_timeout", p), "got no grant, expected one within 64 cycles");
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0)
      fail_evt("drain_timeout", $sformatf("got %0d/%0d pending, expected 0/0", q0.size(), q1.size()));
    @(negedge clk);
  endtask

  // Monitor: records grants and checks every response against the scoreboard
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (dm_r || dm_w) strobe_cnt++;
      if (dm_r && dm_w) both_cnt++;
      if (dm_r) last_rd_addr = dm_addr;
      for (int p = 0; p < 2; p++) begin
        if (gnt[p]) begin
          gnt_cyc[p] = cyc;
          grant_log.push_back(p);
        end
        if (rsp[p]) begin
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            fail_evt($sformatf("p%0d_unexpected_rsp", p), "got rsp, expected none");
          end else begin
            x = (p == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("p%0d_err", p), 32'(err[p]), 32'(x.err));
            check($sformatf("p%0d_rdata", p), rdata[p], x.rdata);
            check($sformatf("p%0d_latency", p), 32'(cyc - gnt_cyc[p]), 32'(x.lat));
          end
        end else if (rdata[p] != 32'h0 || err[p]) begin
          stray++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int n;
    req = '0; we = '0; uns = '0;
    for (int p = 0; p < 2; p++) begin
      sz[p] = '0; addr[p] = '0; wdata[p] = '0;
    end
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_dm_w", 32'(dm_w), 32'h0);
    check("rst_dm_r", 32'(dm_r), 32'h0);
    check("rst_dm_addr", 32'(dm_addr), 32'h0);
    check("rst_dm_wdata", dm_wdata, 32'h0);
    check("rst_rsp", 32'(rsp), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_p0_rdata", rdata[0], 32'h0);
    check("rst_p1_rdata", rdata[1], 32'h0);
    check("store_format", 32'(sfmt), 32'h0);
    rst_n = 1'b1;

    // Both ports contend: p0 first, then alternate
    grant_log.delete();
    fork
      begin
        issue(0, 1'b1, SZ_WORD, 1'b0, 13'h100, 32'h0000_0A00, 1'b0, 32'h0, 2);
        issue(0, 1'b1, SZ_WORD, 1'b0, 13'h104, 32'h0000_0A04, 1'b0, 32'h0, 2);
      end
      begin
        issue(1, 1'b1, SZ_WORD, 1'b0, 13'h108, 32'h0000_0B08, 1'b0, 32'h0, 2);
        issue(1, 1'b1, SZ_WORD, 1'b0, 13'h10C, 32'h0000_0B0C, 1'b0, 32'h0, 2);
      end
    join
    drain();
    check("arb_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      check("arb_g0", 32'(grant_log[0]), 32'd0);
      check("arb_g1", 32'(grant_log[1]), 32'd1);
      check("arb_g2", 32'(grant_log[2]), 32'd0);
      check("arb_g3", 32'(grant_log[3]), 32'd1);
    end
    check("mem_0x104", mem[65], 32'h0000_0A04);
    check("mem_0x108", mem[66], 32'h0000_0B08);

    // Word store then word load
    issue(0, 1'b1, SZ_WORD, 1'b0, 13'h010, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);
    issue(0, 1'b0, SZ_WORD, 1'b0, 13'h010, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);
    drain();
    check("ld_dm_addr", 32'(last_rd_addr), 32'd4);
    check("mem_0x010_word", mem[4], 32'hDEAD_BEEF);

    // Byte store via RMW, then signed/unsigned byte loads
    issue(1, 1'b1, SZ_WORD, 1'b0, 13'h010, 32'h1122_3344, 1'b0, 32'h0, 2);
    issue(0, 1'b1, SZ_BYTE, 1'b0, 13'h013, 32'h1234_56A5, 1'b0, 32'h0, 3);
    drain();
    check("mem_after_byte", mem[4], 32'hA522_3344);
    issue(0, 1'b0, SZ_BYTE, 1'b0, 13'h013, 32'h0, 1'b0, 32'hFFFF_FFA5, 2);
    issue(1, 1'b0, SZ_BYTE, 1'b1, 13'h013, 32'h0, 1'b0, 32'h0000_00A5, 2);

    // Half store in the upper lane, then half/byte loads around it
    issue(1, 1'b1, SZ_HALF, 1'b0, 13'h012, 32'hABCD_8001, 1'b0, 32'h0, 3);
    issue(0, 1'b0, SZ_HALF, 1'b0, 13'h012, 32'h0, 1'b0, 32'hFFFF_8001, 2);
    issue(0, 1'b0, SZ_HALF, 1'b1, 13'h010, 32'h0, 1'b0, 32'h0000_3344, 2);
    issue(1, 1'b0, SZ_BYTE, 1'b0, 13'h011, 32'h0, 1'b0, 32'h0000_0033, 2);
    drain();
    check("mem_after_half", mem[4], 32'h8001_3344);

    // Last populated word is legal
    issue(0, 1'b1, SZ_WORD, 1'b0, 13'h0FFC, 32'h5A5A_0001, 1'b0, 32'h0, 2);
    issue(1, 1'b0, SZ_WORD, 1'b0, 13'h0FFC, 32'h0, 1'b0, 32'h5A5A_0001, 2);
    drain();

    // Errors: respond after one cycle and never touch memory
    s0 = strobe_cnt;
    issue(0, 1'b0, SZ_WORD, 1'b0, 13'h002, 32'h0, 1'b1, 32'h0, 1);
    issue(1, 1'b0, SZ_HALF, 1'b0, 13'h001, 32'h0, 1'b1, 32'h0, 1);
    issue(0, 1'b0, SZ_WORD, 1'b0, 13'h1000, 32'h0, 1'b1, 32'h0, 1);
    issue(1, 1'b1, 2'b11, 1'b0, 13'h004, 32'hDEAD_0000, 1'b1, 32'h0, 1);
    drain();
    check("err_no_strobes", 32'(strobe_cnt - s0), 32'h0);

    // Reset during RMW_RD of a byte store
    issue(0, 1'b1, SZ_WORD, 1'b0, 13'h020, 32'hCAFE_F00D, 1'b0, 32'h0, 2);
    drain();
    @(negedge clk);
    we[1] = 1'b1; sz[1] = SZ_BYTE; uns[1] = 1'b0; addr[1] = 13'h021; wdata[1] = 32'h0000_0077; req[1] = 1'b1;
    #1;
    check("rmw_gnt", 32'(gnt[1]), 32'h1);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    check("rmw_rd_strobe", 32'(dm_r), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_dm_r", 32'(dm_r), 32'h0);
    check("abort_dm_w", 32'(dm_w), 32'h0);
    check("abort_dm_addr", 32'(dm_addr), 32'h0);
    check("abort_dm_wdata", dm_wdata, 32'h0);
    check("abort_rsp", 32'(rsp), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("abort_mem_0x020", mem[8], 32'hCAFE_F00D);

    // After reset the first tie goes to p0 again
    n = grant_log.size();
    fork
      issue(1, 1'b0, SZ_WORD, 1'b0, 13'h020, 32'h0, 1'b0, 32'hCAFE_F00D, 2);
      issue(0, 1'b0, SZ_BYTE, 1'b1, 13'h021, 32'h0, 1'b0, 32'h0000_00F0, 2);
    join
    drain();
    check("rst_tie_count", 32'(grant_log.size() - n), 32'd2);
    if (grant_log.size() == n + 2) begin
      check("rst_tie_first", 32'(grant_log[n]), 32'd0);
      check("rst_tie_second", 32'(grant_log[n+1]), 32'd1);
    end

    check("strobe_exclusive", 32'(both_cnt), 32'h0);
    check("rdata_err_idle_zero", 32'(stray), 32'h0);
    check("scoreboard_empty", 32'(q0.size() + q1.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
